fetch_decode_stage: RTL and testbench
=====================================

Name: fetch_decode_stage

Overview:
- Downstream neighbour of the instruction fetch stage. Accepts a fetched 32-bit MIPS instruction plus the PC+1 word address and decodes it into datapath control and register fields.
- Decoded bundles are buffered in a 2-entry skid buffer with valid/ready handshakes on both sides, so execute-side backpressure never combinationally reaches fetch.
- Supports a flush when a branch or jump redirects fetch.

Parameters:
- PC_W, 30, width of the word-address PC field (matches fetch stage PC).
- INSTR_W, 32, instruction width.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous active-high reset
- in_valid  input  1  fetch presents an instruction
- in_ready  output  1  stage can accept; equals "fewer than 2 entries held", registered
- in_instr  input  32  instruction word
- in_pc1  input  30  PC+1 word address from the fetch adder
- flush  input  1  discard all held and incoming entries this cycle
- out_valid  output  1  head entry valid
- out_ready  input  1  execute consumes head
- out_pc1  output  30  PC+1 of head
- out_rs, out_rt, out_rd  output  5 each  register specifiers
- out_shamt  output  5  shift amount
- out_imm16  output  16  immediate field
- out_target  output  26  jump target field
- out_regwrite, out_memwrite, out_memtoreg, out_alusrc, out_branch, out_jal  output  1 each  control bits
- out_regdst  output  2  00 rt, 01 rd, 10 r31
- out_aluop  output  3  000 ADD, 001 SUB, 010 XOR, 011 SLT, 111 none
- out_jump  output  2  00 sequential, 01 register (JR), 10 target (J/JAL); same encoding the fetch stage consumes
- out_illegal  output  1  head opcode/funct not supported

Behaviour:
- Decoded instruction set: LW 0x23, SW 0x2B, J 0x02, JAL 0x03, BNE 0x05, XORI 0x0E, R-type 0x00 with funct ADD 0x20, SUB 0x22, SLT 0x2A, JR 0x08.
- Control per instruction:
  - LW: regwrite, memtoreg, alusrc, ADD, regdst=00.
  - SW: memwrite, alusrc, ADD.
  - J: jump=10.
  - JAL: jump=10, jal, regwrite, regdst=10.
  - BNE: branch, SUB.
  - XORI: regwrite, alusrc, XOR, regdst=00.
  - ADD/SUB/SLT: regwrite, regdst=01, matching aluop.
  - JR: jump=01.
- Any other encoding decodes as a NOP: all control bits 0, aluop 111, jump 00.
- Field extraction is fixed-position and unconditional; fields pass through for every opcode.
- FSM with states EMPTY, ONE, TWO. Entries are stored in two slots, head and skid.
  - Push = in_valid & in_ready. Pop = out_valid & out_ready.
  - EMPTY: push -> ONE.
  - ONE: push & !pop -> TWO; pop & !push -> EMPTY; push & pop -> ONE (new entry becomes head next cycle).
  - TWO: pop -> ONE (skid moves to head); push is impossible because in_ready=0.
- Latency: an entry accepted at edge N is visible on out_* after edge N (1 cycle). Ordering is strictly FIFO.
- in_ready is a register output: 1 in EMPTY and ONE, 0 in TWO.
- out_valid is 1 in ONE and TWO. While out_valid=1 and out_ready=0, out_* must hold stable.
- Flush has priority over push and pop: next state is EMPTY and the incoming instruction is dropped. Any pop in the same cycle still counts as consumed.
- Reset (async, any state, including mid-handshake): state EMPTY, out_valid=0, in_ready=1, all out_* data and control = 0, aluop=111.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
  - Defined: out_illegal=1 for undecoded encodings; control remains NOP.
  - Undefined: out_illegal is tied to 0 and the illegal-detect logic is not built.

Decomposition:
- Package mips_pkg holds:
  - opcode and funct constants;
  - aluop, regdst and jump localparams;
  - a packed ctrl_t struct bundling the control bits;
  - the FSM state enum.
- One combinational sub-module, instr_decoder (instruction in, ctrl_t plus fields out), is instantiated once at the push side. Decoded bundles are stored, not raw instructions.

Test Plan:
- Reset mid-stream: hold TWO, assert reset asynchronously between edges -> out_valid=0 immediately, in_ready=1, aluop=111.
- Single LW 0x8C220004 with pc1=0x5, out_ready=1 -> next cycle out_valid=1, regwrite=memtoreg=alusrc=1, aluop=000, rs=1, rt=2, imm16=0x0004, out_pc1=0x5.
- Backpressure: push ADD 0x00432020, SUB 0x00432022, JAL 0x0C000010 with out_ready=0 -> in_ready falls after 2 accepts, JAL held off. Release out_ready -> ADD, SUB, JAL emerge in order; JAL shows jump=10, jal=1, regdst=10, target=0x10.
- Flush in TWO with simultaneous in_valid -> next cycle EMPTY, out_valid=0, incoming instruction never appears.
- Simultaneous push/pop in ONE for 8 cycles streaming -> out_valid continuous, one output per cycle, no loss or duplication.
- Illegal 0xFC000000 -> NOP controls; out_illegal=1 only when ILLEGAL_TRAP_EN is defined, else 0.

Source files
------------

// File: rtl/fetch_decode_stage_pkg.sv
// Shared MIPS decode definitions: opcode/funct codes, control encodings,
// the control bundle, the stored entry layout and the stage FSM states.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_XORI  = 6'h0E;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_JR  = 6'h08;
  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD  = 3'b000;
  localparam logic [2:0] ALU_SUB  = 3'b001;
  localparam logic [2:0] ALU_XOR  = 3'b010;
  localparam logic [2:0] ALU_SLT  = 3'b011;
  localparam logic [2:0] ALU_NONE = 3'b111;

  localparam logic [1:0] REGDST_RT  = 2'b00;
  localparam logic [1:0] REGDST_RD  = 2'b01;
  localparam logic [1:0] REGDST_R31 = 2'b10;

  localparam logic [1:0] JUMP_SEQ = 2'b00;
  localparam logic [1:0] JUMP_REG = 2'b01;
  localparam logic [1:0] JUMP_TGT = 2'b10;

  typedef struct packed {
    logic       regwrite;
    logic       memwrite;
    logic       memtoreg;
    logic       alusrc;
    logic       branch;
    logic       jal;
    logic [1:0] regdst;
    logic [2:0] aluop;
    logic [1:0] jump;
    logic       illegal;
  } ctrl_t;

  typedef struct packed {
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [15:0] imm16;
    logic [25:0] target;
  } fields_t;

  typedef struct packed {
    ctrl_t   ctrl;
    fields_t fields;
  } entry_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } state_t;

  localparam ctrl_t CTRL_NOP = '{
    regwrite: 1'b0, memwrite: 1'b0, memtoreg: 1'b0, alusrc: 1'b0,
    branch: 1'b0, jal: 1'b0, regdst: REGDST_RT, aluop: ALU_NONE,
    jump: JUMP_SEQ, illegal: 1'b0
  };

  localparam entry_t ENTRY_RESET = '{ctrl: CTRL_NOP, fields: '0};

  function automatic logic is_legal(input logic [5:0] opcode, input logic [5:0] funct);
    if (opcode == OP_RTYPE)
      return (funct == FN_ADD) || (funct == FN_SUB) || (funct == FN_SLT) || (funct == FN_JR);
    return (opcode == OP_LW) || (opcode == OP_SW) || (opcode == OP_J) || (opcode == OP_JAL) ||
           (opcode == OP_BNE) || (opcode == OP_XORI);
  endfunction

endpackage

// File: rtl/fetch_decode_stage_if.sv
// Fetch-to-decode and decode-to-execute handshake bundle.
// valid/ready: a transfer happens on a rising edge where valid and ready are both 1;
// once valid is raised its payload holds until that edge, and ready never depends on valid.
interface fetch_decode_stage_if #(
  parameter int PC_W    = 30,
  parameter int INSTR_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic [INSTR_W-1:0] in_instr;
  logic [PC_W-1:0]    in_pc1;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [PC_W-1:0]    out_pc1;
  logic [4:0]         out_rs;
  logic [4:0]         out_rt;
  logic [4:0]         out_rd;
  logic [4:0]         out_shamt;
  logic [15:0]        out_imm16;
  logic [25:0]        out_target;
  logic               out_regwrite;
  logic               out_memwrite;
  logic               out_memtoreg;
  logic               out_alusrc;
  logic               out_branch;
  logic               out_jal;
  logic [1:0]         out_regdst;
  logic [2:0]         out_aluop;
  logic [1:0]         out_jump;
  logic               out_illegal;

  modport slave (
    input  in_valid, in_instr, in_pc1, flush, out_ready,
    output in_ready, out_valid, out_pc1, out_rs, out_rt, out_rd, out_shamt,
           out_imm16, out_target, out_regwrite, out_memwrite, out_memtoreg,
           out_alusrc, out_branch, out_jal, out_regdst, out_aluop, out_jump,
           out_illegal
  );

  modport master (
    output in_valid, in_instr, in_pc1, flush, out_ready,
    input  in_ready, out_valid, out_pc1, out_rs, out_rt, out_rd, out_shamt,
           out_imm16, out_target, out_regwrite, out_memwrite, out_memtoreg,
           out_alusrc, out_branch, out_jal, out_regdst, out_aluop, out_jump,
           out_illegal
  );
endinterface

// File: rtl/fetch_decode_stage_decoder.sv
// Combinational MIPS subset decoder: instruction word in, control bundle and fields out.
// out_illegal is only computed when ILLEGAL_TRAP_EN is defined.
module instr_decoder
  import mips_pkg::*;
#(
  parameter int INSTR_W = 32
) (
  input  logic [INSTR_W-1:0] instr,
  output ctrl_t              ctrl,
  output fields_t            fields
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  assign fields.rs     = instr[25:21];
  assign fields.rt     = instr[20:16];
  assign fields.rd     = instr[15:11];
  assign fields.shamt  = instr[10:6];
  assign fields.imm16  = instr[15:0];
  assign fields.target = instr[25:0];

  always_comb begin
    ctrl = CTRL_NOP;
    case (opcode)
      OP_LW: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
        ctrl.regdst   = REGDST_RT;
      end
      OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_ADD;
      end
      OP_J:  ctrl.jump = JUMP_TGT;
      OP_JAL: begin
        ctrl.jump     = JUMP_TGT;
        ctrl.jal      = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = REGDST_R31;
      end
      OP_BNE: begin
        ctrl.branch = 1'b1;
        ctrl.aluop  = ALU_SUB;
      end
      OP_XORI: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluop    = ALU_XOR;
        ctrl.regdst   = REGDST_RT;
      end
      OP_RTYPE: begin
        case (funct)
          FN_ADD, FN_SUB, FN_SLT: begin
            ctrl.regwrite = 1'b1;
            ctrl.regdst   = REGDST_RD;
            ctrl.aluop    = (funct == FN_ADD) ? ALU_ADD :
                            (funct == FN_SUB) ? ALU_SUB : ALU_SLT;
          end
          FN_JR:   ctrl.jump = JUMP_REG;
          default: ctrl = CTRL_NOP;
        endcase
      end
      default: ctrl = CTRL_NOP;
    endcase
`ifdef ILLEGAL_TRAP_EN
    ctrl.illegal = !is_legal(opcode, funct);
`endif
  end

endmodule

// File: rtl/fetch_decode_stage.sv
// Decode stage with a 2-entry skid buffer (head + skid) of decoded bundles.
// Optional feature macro: ILLEGAL_TRAP_EN (flags undecoded encodings on out_illegal).
module fetch_decode_stage
  import mips_pkg::*;
#(
  parameter int PC_W    = 30,
  parameter int INSTR_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  fetch_decode_stage_if.slave   bus,
  output state_t                state
);

  state_t          state_q, state_d;
  logic            in_ready_q;
  entry_t          head_q, skid_q, dec_entry;
  logic [PC_W-1:0] head_pc1_q, skid_pc1_q;
  logic            push, pop;
  logic            load_head_new, load_head_skid, load_skid;

  instr_decoder #(.INSTR_W(INSTR_W)) u_dec (
    .instr  (bus.in_instr),
    .ctrl   (dec_entry.ctrl),
    .fields (dec_entry.fields)
  );

  assign push = bus.in_valid & in_ready_q;
  assign pop  = bus.out_valid & bus.out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_new  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state_q)
      ST_EMPTY: begin
        if (push) begin
          state_d       = ST_ONE;
          load_head_new = 1'b1;
        end
      end
      ST_ONE: begin
        if (push && !pop) begin
          state_d   = ST_TWO;
          load_skid = 1'b1;
        end else if (push && pop) begin
          load_head_new = 1'b1;
        end else if (pop) begin
          state_d = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (pop) begin
          state_d        = ST_ONE;
          load_head_skid = 1'b1;
        end
      end
      default: state_d = ST_EMPTY;
    endcase
    // Flush wins: the incoming instruction is dropped and both slots are abandoned.
    if (bus.flush) begin
      state_d        = ST_EMPTY;
      load_head_new  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_EMPTY;
      in_ready_q <= 1'b1;
      head_q     <= ENTRY_RESET;
      skid_q     <= ENTRY_RESET;
      head_pc1_q <= '0;
      skid_pc1_q <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != ST_TWO);
      if (load_head_new) begin
        head_q     <= dec_entry;
        head_pc1_q <= bus.in_pc1;
      end else if (load_head_skid) begin
        head_q     <= skid_q;
        head_pc1_q <= skid_pc1_q;
      end
      if (load_skid) begin
        skid_q     <= dec_entry;
        skid_pc1_q <= bus.in_pc1;
      end
    end
  end

  assign state          = state_q;
  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = (state_q != ST_EMPTY);
  assign bus.out_pc1    = head_pc1_q;
  assign bus.out_rs     = head_q.fields.rs;
  assign bus.out_rt     = head_q.fields.rt;
  assign bus.out_rd     = head_q.fields.rd;
  assign bus.out_shamt  = head_q.fields.shamt;
  assign bus.out_imm16  = head_q.fields.imm16;
  assign bus.out_target = head_q.fields.target;
  assign bus.out_regwrite = head_q.ctrl.regwrite;
  assign bus.out_memwrite = head_q.ctrl.memwrite;
  assign bus.out_memtoreg = head_q.ctrl.memtoreg;
  assign bus.out_alusrc   = head_q.ctrl.alusrc;
  assign bus.out_branch   = head_q.ctrl.branch;
  assign bus.out_jal      = head_q.ctrl.jal;
  assign bus.out_regdst   = head_q.ctrl.regdst;
  assign bus.out_aluop    = head_q.ctrl.aluop;
  assign bus.out_jump     = head_q.ctrl.jump;
  assign bus.out_illegal  = head_q.ctrl.illegal;

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: reset, decode, backpressure, flush,
// streaming and illegal-encoding checks with hand-computed expectations.
module tb_fetch_decode_stage;
  import mips_pkg::*;

  logic   clk = 1'b0;
  logic   reset = 1'b1;
  state_t dbg_state;
  int     n_cmp = 0;
  int     n_err = 0;
  logic [29:0] exp_q[$];

`ifdef ILLEGAL_TRAP_EN
  localparam logic EXP_ILL = 1'b1;
`else
  localparam logic EXP_ILL = 1'b0;
`endif

  fetch_decode_stage_if #(.PC_W(30), .INSTR_W(32)) bus ();

  fetch_decode_stage #(.PC_W(30), .INSTR_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .state (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [29:0] pc1);
    bus.in_valid = v;
    bus.in_instr = instr;
    bus.in_pc1   = pc1;
  endtask

  // Stream table: LW, SW, J, JR, BNE, XORI, SLT, ADD with expected aluop/jump.
  logic [31:0] s_instr [8] = '{32'h8C220004, 32'hAC220008, 32'h08000100, 32'h03E00008,
                               32'h14E8FFFE, 32'h38A6BEEF, 32'h0043202A, 32'h00432020};
  logic [2:0]  s_aluop [8] = '{3'd0, 3'd0, 3'd7, 3'd7, 3'd1, 3'd2, 3'd3, 3'd0};
  logic [1:0]  s_jump  [8] = '{2'd0, 2'd0, 2'd2, 2'd1, 2'd0, 2'd0, 2'd0, 2'd0};

  initial begin
    drive(1'b0, 32'h0, 30'h0);
    bus.flush     = 1'b0;
    bus.out_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus.in_ready), 32'd1);
    check("rst_aluop",     32'(bus.out_aluop), 32'd7);
    check("rst_regwrite",  32'(bus.out_regwrite), 32'd0);
    check("rst_pc1",       32'(bus.out_pc1), 32'd0);
    check("rst_state",     32'(dbg_state), 32'(ST_EMPTY));

    // Single LW
    drive(1'b1, 32'h8C220004, 30'h5);
    bus.out_ready = 1'b1;
    tick();
    drive(1'b0, 32'h0, 30'h0);
    check("lw_valid",    32'(bus.out_valid), 32'd1);
    check("lw_regwrite", 32'(bus.out_regwrite), 32'd1);
    check("lw_memtoreg", 32'(bus.out_memtoreg), 32'd1);
    check("lw_alusrc",   32'(bus.out_alusrc), 32'd1);
    check("lw_memwrite", 32'(bus.out_memwrite), 32'd0);
    check("lw_aluop",    32'(bus.out_aluop), 32'd0);
    check("lw_regdst",   32'(bus.out_regdst), 32'd0);
    check("lw_rs",       32'(bus.out_rs), 32'd1);
    check("lw_rt",       32'(bus.out_rt), 32'd2);
    check("lw_imm16",    32'(bus.out_imm16), 32'h0004);
    check("lw_pc1",      32'(bus.out_pc1), 32'h5);
    tick();
    check("lw_drained", 32'(bus.out_valid), 32'd0);

    // Backpressure: ADD, SUB accepted, JAL held off
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00432020, 30'd10);
    tick();
    check("bp_state_one", 32'(dbg_state), 32'(ST_ONE));
    check("bp_ready_one", 32'(bus.in_ready), 32'd1);
    drive(1'b1, 32'h00432022, 30'd11);
    tick();
    check("bp_ready_two", 32'(bus.in_ready), 32'd0);
    check("bp_state_two", 32'(dbg_state), 32'(ST_TWO));
    check("bp_head_pc1",  32'(bus.out_pc1), 32'd10);
    check("bp_add_rd",    32'(bus.out_rd), 32'd4);
    check("bp_add_regdst", 32'(bus.out_regdst), 32'd1);
    drive(1'b1, 32'h0C000010, 30'd12);
    tick();
    tick();
    check("bp_hold_pc1",   32'(bus.out_pc1), 32'd10);
    check("bp_hold_aluop", 32'(bus.out_aluop), 32'd0);
    check("bp_hold_ready", 32'(bus.in_ready), 32'd0);
    bus.out_ready = 1'b1;
    tick();
    check("bp_sub_pc1",   32'(bus.out_pc1), 32'd11);
    check("bp_sub_aluop", 32'(bus.out_aluop), 32'd1);
    check("bp_sub_valid", 32'(bus.out_valid), 32'd1);
    tick();
    drive(1'b0, 32'h0, 30'h0);
    check("bp_jal_pc1",    32'(bus.out_pc1), 32'd12);
    check("bp_jal_jump",   32'(bus.out_jump), 32'd2);
    check("bp_jal_jal",    32'(bus.out_jal), 32'd1);
    check("bp_jal_rw",     32'(bus.out_regwrite), 32'd1);
    check("bp_jal_regdst", 32'(bus.out_regdst), 32'd2);
    check("bp_jal_target", 32'(bus.out_target), 32'h10);
    check("bp_jal_aluop",  32'(bus.out_aluop), 32'd7);
    tick();
    check("bp_drained", 32'(bus.out_valid), 32'd0);

    // Flush in TWO with in_valid asserted
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h38A6BEEF, 30'd20);
    tick();
    drive(1'b1, 32'h14E8FFFE, 30'd21);
    tick();
    check("fl_xori_rw",    32'(bus.out_regwrite), 32'd1);
    check("fl_xori_alu",   32'(bus.out_aluop), 32'd2);
    check("fl_xori_imm",   32'(bus.out_imm16), 32'hBEEF);
    check("fl_xori_rt",    32'(bus.out_rt), 32'd6);
    check("fl_state_two",  32'(dbg_state), 32'(ST_TWO));
    drive(1'b1, 32'hAC220008, 30'd22);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 30'h0);
    check("fl2_valid", 32'(bus.out_valid), 32'd0);
    check("fl2_ready", 32'(bus.in_ready), 32'd1);
    check("fl2_state", 32'(dbg_state), 32'(ST_EMPTY));
    tick();
    check("fl2_still_empty", 32'(bus.out_valid), 32'd0);

    // Flush in ONE drops a push that would otherwise be accepted
    drive(1'b1, 32'hAC220008, 30'd30);
    tick();
    check("fl1_one", 32'(dbg_state), 32'(ST_ONE));
    drive(1'b1, 32'h8C220004, 30'd31);
    bus.flush = 1'b1;
    tick();
    bus.flush = 1'b0;
    drive(1'b0, 32'h0, 30'h0);
    check("fl1_valid", 32'(bus.out_valid), 32'd0);
    tick();
    check("fl1_dropped", 32'(bus.out_valid), 32'd0);

    // Streaming: push and pop every cycle
    bus.out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, s_instr[i], 30'(40 + i));
      exp_q.push_back(30'(40 + i));
      tick();
      check("st_valid", 32'(bus.out_valid), 32'd1);
      check("st_ready", 32'(bus.in_ready), 32'd1);
      check("st_pc1",   32'(bus.out_pc1), 32'(exp_q.pop_front()));
      check("st_aluop", 32'(bus.out_aluop), 32'(s_aluop[i]));
      check("st_jump",  32'(bus.out_jump), 32'(s_jump[i]));
    end
    drive(1'b0, 32'h0, 30'h0);
    tick();
    check("st_drained", 32'(bus.out_valid), 32'd0);
    check("st_queue_empty", 32'(exp_q.size()), 32'd0);

    // Illegal encodings
    drive(1'b1, 32'hFC000000, 30'd50);
    tick();
    check("il_valid",   32'(bus.out_valid), 32'd1);
    check("il_rw",      32'(bus.out_regwrite), 32'd0);
    check("il_aluop",   32'(bus.out_aluop), 32'd7);
    check("il_jump",    32'(bus.out_jump), 32'd0);
    check("il_illegal", 32'(bus.out_illegal), 32'(EXP_ILL));
    drive(1'b1, 32'h00000000, 30'd51);
    tick();
    drive(1'b0, 32'h0, 30'h0);
    check("il_sll_aluop",   32'(bus.out_aluop), 32'd7);
    check("il_sll_illegal", 32'(bus.out_illegal), 32'(EXP_ILL));
    drive(1'b1, 32'h00432022, 30'd52);
    tick();
    drive(1'b0, 32'h0, 30'h0);
    check("il_sub_legal", 32'(bus.out_illegal), 32'd0);
    tick();

    // Asynchronous reset while holding TWO
    bus.out_ready = 1'b0;
    drive(1'b1, 32'h00432020, 30'd60);
    tick();
    drive(1'b1, 32'h00432022, 30'd61);
    tick();
    drive(1'b0, 32'h0, 30'h0);
    check("ar_two", 32'(dbg_state), 32'(ST_TWO));
    #3;
    reset = 1'b1;
    #1;
    check("ar_valid", 32'(bus.out_valid), 32'd0);
    check("ar_ready", 32'(bus.in_ready), 32'd1);
    check("ar_aluop", 32'(bus.out_aluop), 32'd7);
    check("ar_pc1",   32'(bus.out_pc1), 32'd0);
    check("ar_rd",    32'(bus.out_rd), 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("ar_after_state", 32'(dbg_state), 32'(ST_EMPTY));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
